prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_pkg.sv | 31 +++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the program loader and the processor side that
// consumes the loaded image: loader states, word width and byte order.
package prog_pkg;

  // Program memory word width; one word is two stream bytes.
  localparam int PROG_DATA_W = 16;

  // Byte order inside a word: the first payload byte is the high byte.
  localparam int HI_BYTE_LSB = 8;
  localparam int LO_BYTE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } prog_state_e;

  // Assemble a memory word from its two stream bytes.
  function automatic logic [PROG_DATA_W-1:0] pack_word(input logic [7:0] hi,
                                                       input logic [7:0] lo);
    logic [PROG_DATA_W-1:0] w;
    w = '0;
    w[HI_BYTE_LSB +: 8] = hi;
    w[LO_BYTE_LSB +: 8] = lo;
    return w;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses ADDR, LEN, LEN x {HI,LO} (and an
// optional CSUM byte) and writes the words into program memory.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader
  import prog_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = PROG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // State entered once the payload (or a zero LEN) has been consumed.
`ifdef PROG_LOADER_CSUM_EN
  localparam prog_state_e TAIL_ST = ST_CSUM;
`else
  localparam prog_state_e TAIL_ST = ST_DONE;
`endif

  prog_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        cnt_q;
  logic [7:0]        hi_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              accept;

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum_q;
  logic              err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Reset gates in_ready directly so no byte is taken while rst is high.
  assign in_ready  = ~rst && (state_q != ST_DONE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next write address wraps naturally at 2^ADDR_W.
  assign addr_d = addr_q + ADDR_W'(1);

  // Frame parser FSM with registered memory-write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          addr_q  <= ADDR_W'(in_data);
          state_q <= ST_LEN;
`ifdef PROG_LOADER_CSUM_EN
          csum_q  <= in_data;
          err_q   <= 1'b0;
`endif
        end
        ST_LEN: if (accept) begin
          cnt_q   <= in_data;
          state_q <= (in_data == 8'd0) ? TAIL_ST : ST_HI;
`ifdef PROG_LOADER_CSUM_EN
          csum_q  <= csum_q + in_data;
`endif
        end
        ST_HI: if (accept) begin
          hi_q    <= in_data;
          state_q <= ST_LO;
`ifdef PROG_LOADER_CSUM_EN
          csum_q  <= csum_q + in_data;
`endif
        end
        ST_LO: if (accept) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= DATA_W'(pack_word(hi_q, in_data));
          addr_q      <= addr_d;
          cnt_q       <= cnt_q - 8'd1;
          state_q     <= (cnt_q == 8'd1) ? TAIL_ST : ST_HI;
`ifdef PROG_LOADER_CSUM_EN
          csum_q      <= csum_q + in_data;
`endif
        end
`ifdef PROG_LOADER_CSUM_EN
        ST_CSUM: if (accept) begin
          err_q   <= (in_data != csum_q);
          state_q <= ST_DONE;
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a frame-level model.
module tb_prog_loader;
  import prog_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  wr_t         cmp_e;
  int          done_seen = 0;
  logic        exp_err = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] frame_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {3'b0, in_ready, mem_we, busy, done, err, mem_addr, mem_wdata}, 32'h0);
      prev_done = 1'b0;
    end else begin
      if (mem_we) begin
        obs_q.push_back('{mem_addr, mem_wdata});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          cmp_e = exp_q.pop_front();
          check("write_addr", {24'h0, mem_addr}, {24'h0, cmp_e.a});
          check("write_data", {16'h0, mem_wdata}, {16'h0, cmp_e.d});
        end
      end
      if (done) begin
        check("done_after_writes", exp_q.size(), 0);
        check("done_err", {31'h0, err}, {31'h0, exp_err});
        check("done_flags", {30'h0, busy, in_ready}, 32'h2);
        done_seen++;
      end
      if (prev_done)
        check("post_done_idle", {28'h0, busy, done, in_ready, err}, {28'h0, 3'b001, exp_err});
      prev_done = done;
    end
  end

  // Present one byte after a random gap and wait (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  g;
    bit  ok;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
    end
  endtask

  // Send ADDR, LEN, frame_words (and CSUM when enabled); abort_after>=0
  // sends only that many bytes and then applies reset.
  task automatic run_frame(input logic [7:0] addr, input int max_gap,
                           input logic [7:0] csum_delta, input int abort_after);
    logic [7:0] bytes[$];
    logic [7:0] s;
    logic [7:0] len;
    int         target;
    int         nsend;
    bit         seen;
    len = 8'(frame_words.size());
    bytes.push_back(addr);
    bytes.push_back(len);
    foreach (frame_words[i]) begin
      bytes.push_back(frame_words[i][15:8]);
      bytes.push_back(frame_words[i][7:0]);
    end
    s = 8'h0;
    foreach (bytes[i]) s = s + bytes[i];
`ifdef PROG_LOADER_CSUM_EN
    bytes.push_back(s + csum_delta);
    exp_err = (csum_delta != 8'h0);
`else
    exp_err = 1'b0;
`endif
    nsend = (abort_after >= 0) ? abort_after : bytes.size();
    // A word is written iff its low byte (stream index 3+2i) gets sent.
    foreach (frame_words[i])
      if (3 + 2 * i < nsend) exp_q.push_back('{8'(addr + 8'(i)), frame_words[i]});
    target = done_seen + 1;
    for (int i = 0; i < nsend; i++) send_byte(bytes[i], max_gap);
    if (abort_after >= 0) begin
      @(posedge clk); #1;
      rst = 1'b1;
      exp_err = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      check("abort_no_done", done_seen, target - 1);
    end else begin
      seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (done_seen >= target) begin seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      check("done_pulse_seen", {31'h0, seen}, 32'h1);
      @(posedge clk); #1;
    end
    check("all_writes_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int nw;
    int ab;
    logic [7:0] dl;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {29'h0, in_ready, busy, done}, 32'h4);
    @(posedge clk); #1;

    // Back-to-back frame 00,02,01,05,00,07.
    obs_q.delete();
    frame_words = '{16'h0105, 16'h0007};
    run_frame(8'h00, 0, 8'h00, -1);
    check("b2b_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("b2b_w0", {8'h0, obs_q[0].a, obs_q[0].d}, 32'h00_0105);
      check("b2b_w1", {8'h0, obs_q[1].a, obs_q[1].d}, 32'h01_0007);
    end

    // Address wrap from FF to 00.
    obs_q.delete();
    frame_words = '{16'h1111, 16'h2222};
    run_frame(8'hFF, 0, 8'h00, -1);
    check("wrap_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("wrap_w0", {8'h0, obs_q[0].a, obs_q[0].d}, 32'hFF_1111);
      check("wrap_w1", {8'h0, obs_q[1].a, obs_q[1].d}, 32'h00_2222);
    end

    // Zero-length frame: no writes, done still pulses.
    obs_q.delete();
    frame_words.delete();
    run_frame(8'h33, 0, 8'h00, -1);
    check("len0_no_write", obs_q.size(), 0);

    // Same content as the back-to-back frame with random gaps.
    obs_q.delete();
    frame_words = '{16'h0105, 16'h0007};
    run_frame(8'h00, 5, 8'h00, -1);
    check("gap_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("gap_w0", {8'h0, obs_q[0].a, obs_q[0].d}, 32'h00_0105);
      check("gap_w1", {8'h0, obs_q[1].a, obs_q[1].d}, 32'h01_0007);
    end

    // Reset after the high byte of the second word.
    obs_q.delete();
    frame_words = '{16'h0105, 16'h0007};
    run_frame(8'h00, 0, 8'h00, 5);
    check("abort_count", obs_q.size(), 1);
    if (obs_q.size() == 1)
      check("abort_w0", {8'h0, obs_q[0].a, obs_q[0].d}, 32'h00_0105);

`ifdef PROG_LOADER_CSUM_EN
    // Frame 10,01,AB,CD: CSUM 89 is good, 88 is bad.
    frame_words = '{16'hABCD};
    run_frame(8'h10, 0, 8'h00, -1);
    check("csum_good_err", {31'h0, err}, 32'h0);
    run_frame(8'h10, 0, 8'hFF, -1);
    check("csum_bad_err", {31'h0, err}, 32'h1);
`endif

    // Randomized frames, with occasional mid-payload reset.
    for (int f = 0; f < 30; f++) begin
      nw = int'($urandom_range(8, 0));
      frame_words.delete();
      for (int i = 0; i < nw; i++) frame_words.push_back(16'($urandom));
      dl = ($urandom_range(9, 0) < 3) ? 8'($urandom_range(255, 1)) : 8'h00;
      ab = -1;
      if (nw > 0 && $urandom_range(9, 0) == 0)
        ab = int'($urandom_range(1 + 2 * nw, 2));
      run_frame(8'($urandom), int'($urandom_range(5, 0)), dl, ab);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
